md_unit: RTL and testbench
==========================

# md_unit

Iterative 32-bit multiply/divide unit for the MCU datapath with architectural HI/LO registers. It accepts one operation at a time from the decode/execute stage, computes over 32 cycles, and holds the result in HI/LO. HI/LO feed the write-back 32-bit 2:1 selection stage, and busy stalls the pipeline.

## Interface
- Parameters: none; width is fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  32  multiplicand or dividend; sampled with `start`.
- `b`  in  32  multiplier or divisor; sampled with `start`.
- `hi_we`  in  1  direct HI write (MTHI).
- `lo_we`  in  1  direct LO write (MTLO).
- `wdata`  in  32  data for `hi_we`/`lo_we`.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register; high product word or remainder.
- `lo`  out  32  LO register; low product word or quotient.

## Operation
- FSM states: IDLE, CALC.
  - IDLE -> CALC on `start`.
  - CALC -> IDLE when the iteration counter reaches 31.
- On accept, latch the operands and op. Signed ops latch |a| and |b| and record the result signs.
- Multiply: 32 shift-add steps on a 64-bit accumulator.
- Divide: 32 restoring shift-subtract steps.
- Signed fix-up on completion:
  - Product is negated if sign(a)≠sign(b).
  - Quotient is negated if sign(a)≠sign(b).
  - Remainder takes the sign of `a`.
- Results by op:
  - MULT/MULTU: `hi`/`lo` = product[63:32]/[31:0].
  - DIV/DIVU: `lo` = quotient, `hi` = remainder.
- Divide by zero: `lo`=0xFFFF_FFFF and `hi`=a, unsigned or signed. No trap.
- DIV 0x8000_0000 / 0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0.
- `start` while `busy`=1 is ignored, and operands are not resampled.
- `hi_we`/`lo_we` while `busy`=1 are ignored.
- In IDLE, the target register takes `wdata` at the next edge.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the write is dropped.
- `hi_we` and `lo_we` together: both registers take `wdata`.
- Reset, including mid-operation: FSM goes to IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. The in-flight operation is discarded and no `done` is issued.

## Timing
- `start` is sampled at edge E0. `busy` is 1 from after E0 through E32.
- At E32, `hi`/`lo` update and `busy` falls. `done`=1 for the single cycle between E32 and E33.
- Latency is 32 cycles, start edge to result visible. Throughput is one op per 33 cycles.
- A new `start` can be accepted at E33, i.e. in the same cycle that `done` is high.
- `hi`/`lo` hold their old values during CALC. They are registered outputs with no combinational path from the inputs.
- The direct-write path updates at the edge after `hi_we`/`lo_we`, with 1-cycle latency.

## Configuration
- `MD_SIGNED_EN`
  - Defined: MULT and DIV use signed magnitude conversion and sign fix-up as above.
  - Undefined: `op[0]` is ignored, MULT behaves as MULTU and DIV as DIVU, and the sign fix-up logic is not built.

## Structure
- Shared datapath package holds:
  - op encoding constants: `MD_MULTU`, `MD_MULT`, `MD_DIVU`, `MD_DIV`;
  - `MD_ITER`=32;
  - the FSM state constants.
- Sub-module `md_abs_neg`: combinational 32-bit conditional two's-complement negate. It is used for operand magnitudes and for result fix-up.
- The iteration datapath and FSM stay in `md_unit`.

## Test plan
- MULTU a=0xFFFF_FFFF, b=2 -> `busy` 32 cycles, `done` at E32+, `hi`=0x0000_0001, `lo`=0xFFFF_FFFE.
- MULT a=0xFFFF_FFFD (-3), b=5 -> `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFF1.
- DIVU 100/7 -> `lo`=14, `hi`=2.
- DIV 0xFFFF_FFF9 (-7)/2 -> `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF.
- Divide by zero and direct write:
  - DIVU 5/0 -> `lo`=0xFFFF_FFFF, `hi`=5.
  - Then `hi_we`, `wdata`=0x1234 in IDLE -> `hi`=0x0000_1234 next cycle.
- Control corner cases:
  - `start` pulsed at cycle 5 of busy -> ignored, the first result is unchanged.
  - `rst` asserted at cycle 10 of CALC -> `busy`=0, `hi`=`lo`=0 immediately, no `done`.
  - `start` and `lo_we` together in IDLE -> op starts, LO is not written.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings,
// iteration count and the FSM state type.
package md_unit_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam int         MD_ITER  = 32;
    localparam logic [4:0] MD_LAST  = 5'(MD_ITER - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_abs_neg.sv
// Conditional 32-bit two's-complement negate, used both to take operand
// magnitudes and to restore result signs.
module md_abs_neg (
    input  logic        neg,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = neg ? (~din + 32'd1) : din;

endmodule

// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (32 steps per op).
// Build option: MD_SIGNED_EN enables signed MULT/DIV; otherwise op[0] is ignored.
module md_unit
    import md_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state, state_next;
    logic [4:0]  cnt;
    logic [63:0] acc, acc_next;
    logic [31:0] opnd;
    logic        is_div;
    logic        div_zero;
    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [31:0] hi_raw, lo_raw, hi_res, lo_res;

`ifdef MD_SIGNED_EN
    logic        res_neg;
    logic        rem_neg;
    logic [31:0] hi_fix, lo_fix;

    assign signed_op = op[0];
`else
    logic        unused_op0;

    assign signed_op  = 1'b0;
    assign unused_op0 = op[0];
`endif

    assign busy = (state == ST_CALC);

    md_abs_neg u_a_abs (.neg(signed_op & a[31]), .din(a), .dout(a_mag));
    md_abs_neg u_b_abs (.neg(signed_op & b[31]), .din(b), .dout(b_mag));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (cnt == MD_LAST) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One iteration: acc holds {partial product, multiplier} for multiply
    // and {remainder, dividend/quotient} for restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, opnd};
        acc_next  = {mul_sum, acc[31:1]};
        if (is_div) begin
            if (div_diff[32]) begin
                acc_next = {div_shift[31:0], acc[30:0], 1'b0};
            end else begin
                acc_next = {div_diff[31:0], acc[30:0], 1'b1};
            end
        end
    end

    assign hi_raw = acc_next[63:32];
    assign lo_raw = acc_next[31:0];

`ifdef MD_SIGNED_EN
    // A 64-bit negate only carries into the high word when the low word is zero.
    md_abs_neg u_lo_fix (.neg(res_neg), .din(lo_raw), .dout(lo_fix));
    md_abs_neg u_hi_fix (
        .neg (is_div ? rem_neg : (res_neg & (lo_raw == 32'd0))),
        .din (hi_raw),
        .dout(hi_fix)
    );

    always_comb begin
        hi_res = hi_fix;
        lo_res = lo_fix;
        if (!is_div && res_neg && (lo_raw != 32'd0)) hi_res = ~hi_raw;
        if (div_zero) lo_res = 32'hFFFF_FFFF;
    end
`else
    always_comb begin
        hi_res = hi_raw;
        lo_res = div_zero ? 32'hFFFF_FFFF : lo_raw;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
`ifdef MD_SIGNED_EN
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    cnt      <= 5'd0;
                    is_div   <= op[1];
                    div_zero <= op[1] & (b == 32'd0);
                    if (op[1]) begin
                        acc  <= {32'd0, a_mag};
                        opnd <= b_mag;
                    end else begin
                        acc  <= {32'd0, b_mag};
                        opnd <= a_mag;
                    end
`ifdef MD_SIGNED_EN
                    res_neg <= signed_op & (a[31] ^ b[31]);
                    rem_neg <= signed_op & a[31];
`endif
                end else begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
            end else begin
                acc <= acc_next;
                cnt <= cnt + 5'd1;
                if (cnt == MD_LAST) begin
                    cnt  <= 5'd0;
                    hi   <= hi_res;
                    lo   <= lo_res;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;

    md_unit dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic               sgn;
        logic signed [63:0] sp;
        logic signed [31:0] sx, sy, sq, sr;
        logic [31:0]        q, r;
        sgn = o[0];
`ifndef MD_SIGNED_EN
        sgn = 1'b0;
`endif
        if (!o[1]) begin
            if (sgn) begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            return {32'd0, x} * {32'd0, y};
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sx = x;
            sy = y;
            sq = sx / sy;
            sr = sx % sy;
            return {sr, sq};
        end
        q = x / y;
        r = x % y;
        return {r, q};
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rhi = hi;
        rlo = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared += 4;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
        if (lo !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  ops[8]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01};
        logic [31:0] as[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                                 32'd5, 32'h8000_0000, 32'hFFFF_FFF0, 32'h8000_0000};
        logic [31:0] bs[8]   = '{32'd2, 32'd5, 32'd7, 32'd2,
                                 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        logic [31:0] rhi, rlo;
        logic [63:0] exp;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            exp = model(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], rhi, rlo, lat);
            compared += 3;
            if (lat != 32) begin mismatched++; $display("[TB] FAIL dir%0d_latency got %0d want 32", i, lat); end
            if (rhi !== exp[63:32]) begin mismatched++; $display("[TB] FAIL dir%0d_hi got %h want %h", i, rhi, exp[63:32]); end
            if (rlo !== exp[31:0]) begin mismatched++; $display("[TB] FAIL dir%0d_lo got %h want %h", i, rlo, exp[31:0]); end
            @(negedge clk);
            compared += 2;
            if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL dir%0d_done_pulse got %b want 0", i, done); end
            if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL dir%0d_busy_after got %b want 0", i, busy); end
        end
    endtask

    task automatic test_direct_write();
        logic [31:0] v, w, rhi, rlo;
        logic [63:0] exp;
        int          lat;
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        v = $urandom;
        lo_we = 1'b1; wdata = v;
        @(negedge clk);
        lo_we = 1'b0;
        compared += 2;
        if (hi !== 32'h0000_1234) begin mismatched++; $display("[TB] FAIL mthi got %h want 00001234", hi); end
        if (lo !== v) begin mismatched++; $display("[TB] FAIL mtlo got %h want %h", lo, v); end
        w = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = w;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        compared += 2;
        if (hi !== w) begin mismatched++; $display("[TB] FAIL both_we_hi got %h want %h", hi, w); end
        if (lo !== w) begin mismatched++; $display("[TB] FAIL both_we_lo got %h want %h", lo, w); end
        // Writes during an operation must be dropped and HI/LO must hold.
        exp = model(2'b00, 32'd123456, 32'd789);
        start = 1'b1; op = 2'b00; a = 32'd123456; b = 32'd789;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = ~w;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        compared += 2;
        if (hi !== w) begin mismatched++; $display("[TB] FAIL busy_we_hi got %h want %h", hi, w); end
        if (lo !== w) begin mismatched++; $display("[TB] FAIL busy_we_lo got %h want %h", lo, w); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        rhi = hi; rlo = lo;
        compared += 2;
        if (rhi !== exp[63:32]) begin mismatched++; $display("[TB] FAIL busy_we_res_hi got %h want %h", rhi, exp[63:32]); end
        if (rlo !== exp[31:0]) begin mismatched++; $display("[TB] FAIL busy_we_res_lo got %h want %h", rlo, exp[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [63:0] exp;
        int          lat;
        exp = model(2'b10, 32'd100, 32'd7);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        compared += 3;
        if (lat != 32) begin mismatched++; $display("[TB] FAIL ign_latency got %0d want 32", lat); end
        if (hi !== exp[63:32]) begin mismatched++; $display("[TB] FAIL ign_hi got %h want %h", hi, exp[63:32]); end
        if (lo !== exp[31:0]) begin mismatched++; $display("[TB] FAIL ign_lo got %h want %h", lo, exp[31:0]); end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ign_busy_after got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        start = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        compared += 4;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done got %b want 0", done); end
        if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_hi got %h want 0", hi); end
        if (lo !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_lo got %h want 0", lo); end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        compared++;
        if (seen_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_activity got %b want 0", seen_done); end
    endtask

    task automatic test_start_lo_we();
        logic [31:0] old;
        logic [63:0] exp;
        int          lat;
        old = $urandom;
        lo_we = 1'b1; wdata = old;
        @(negedge clk);
        exp = model(2'b00, 32'd77, 32'd3);
        start = 1'b1; op = 2'b00; a = 32'd77; b = 32'd3; wdata = ~old;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        compared += 2;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL startwe_busy got %b want 1", busy); end
        if (lo !== old) begin mismatched++; $display("[TB] FAIL startwe_lo_hold got %h want %h", lo, old); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        compared += 2;
        if (lat != 32) begin mismatched++; $display("[TB] FAIL startwe_latency got %0d want 32", lat); end
        if (lo !== exp[31:0]) begin mismatched++; $display("[TB] FAIL startwe_lo got %h want %h", lo, exp[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rhi, rlo;
        logic [63:0] exp;
        int          lat;
        run_op(2'b10, 32'd1000, 32'd33, rhi, rlo, lat);
        exp = model(2'b01, 32'hFFFF_FF00, 32'h0000_0300);
        run_op(2'b01, 32'hFFFF_FF00, 32'h0000_0300, rhi, rlo, lat);
        compared += 3;
        if (lat != 32) begin mismatched++; $display("[TB] FAIL b2b_latency got %0d want 32", lat); end
        if (rhi !== exp[63:32]) begin mismatched++; $display("[TB] FAIL b2b_hi got %h want %h", rhi, exp[63:32]); end
        if (rlo !== exp[31:0]) begin mismatched++; $display("[TB] FAIL b2b_lo got %h want %h", rlo, exp[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, rhi, rlo;
        logic [63:0] exp;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 100));
                2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
                default: y = $urandom;
            endcase
            exp = model(o, x, y);
            run_op(o, x, y, rhi, rlo, lat);
            compared += 3;
            if (lat != 32) begin mismatched++; $display("[TB] FAIL rnd%0d_latency got %0d want 32", i, lat); end
            if (rhi !== exp[63:32]) begin mismatched++; $display("[TB] FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, x, y, rhi, exp[63:32]); end
            if (rlo !== exp[31:0]) begin mismatched++; $display("[TB] FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, x, y, rlo, exp[31:0]); end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_direct_write();
        test_start_ignored();
        test_reset_mid();
        test_start_lo_we();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
